eight_bit_divider_module: RTL and testbench



---
 rtl/eight_bit_divider_module.sv | 174 +++++++++++++++++
 tb/tb_eight_bit_divider_module.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/eight_bit_divider_module.sv
// Iterative restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module eight_bit_divider_module #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_neg;

`ifdef DIV_SIGNED_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;

  assign a_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
  assign b_mag = divisor[WIDTH-1] ? (~divisor + ONE) : divisor;
  assign quo_fix = (sa_q ^ sb_q) ? (~acc_q + ONE) : acc_q;
  assign rem_fix = sa_q ? (~prem_q + ONE) : prem_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end

  always_comb begin
    sa_d = sa_q;
    sb_d = sb_q;
    if (state_q == S_IDLE && start) begin
      sa_d = dividend[WIDTH-1];
      sb_d = divisor[WIDTH-1];
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign quo_fix = acc_q;
  assign rem_fix = prem_q;
`endif

  // Trial subtraction is one bit wider so bit WIDTH acts as the sign.
  assign shifted = {prem_q, acc_q[WIDTH-1]};
  assign trial = shifted - {1'b0, dvs_q};
  assign trial_neg = trial[WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvs_d  = b_mag;
          prem_d = '0;
          cnt_d  = CNT_INIT;
          if (divisor == '0) begin
            // Raw dividend is parked here to become the remainder.
            acc_d   = dividend;
            state_d = S_DONE;
          end else begin
            acc_d   = a_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        prem_d = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        acc_d  = {acc_q[WIDTH-2:0], ~trial_neg};
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (dvs_q == '0) begin
          quo_d = '1;
          rem_d = acc_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = quo_fix;
          rem_d = rem_fix;
          dbz_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CALC);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_eight_bit_divider_module.sv
// Scoreboard bench for eight_bit_divider_module.
// Expected results are modelled in the bench; DIV_SIGNED_EN adds signed cases.
module tb_eight_bit_divider_module;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  eight_bit_divider_module #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic [7:0]   lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int qi;
    int ri;
    e.lat = (b == 0) ? 8'd1 : 8'(W + 1);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sbv;
      sa = $signed(a);
      sbv = $signed(b);
      qi = sa / sbv;
      ri = sa % sbv;
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    step();
    start = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    int k;
    int bcnt;
    exp_t e;
    issue(a, b);
    k = 0;
    bcnt = busy ? 1 : 0;
    while (!done && k < 20) begin
      step();
      k++;
      if (busy) bcnt++;
    end
    chk({tag, "_done"}, done, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (done) begin
        chk({tag, "_q"}, quotient, e.q);
        chk({tag, "_r"}, remainder, e.r);
        chk({tag, "_dbz"}, div_by_zero, e.z);
        chk({tag, "_lat"}, k, e.lat);
        chk({tag, "_busy"}, bcnt, e.z ? 0 : W);
      end
    end
  endtask

  initial begin
    int nd;
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset_n = 1'b1;
    step();

    run_op(8'd200, 8'd7, "basic");
    chk("basic_q_const", quotient, 8'h1C);
    step();
    chk("done_pulse", done, 0);

    dividend = 8'd200;
    divisor = 8'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    step();
    step();
    reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) nd++;
    end
    chk("arst_no_done", nd, 0);
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_q", quotient, 0);

    run_op(8'd255, 8'd1, "b255_1");
    run_op(8'd5, 8'd9, "b5_9");
    run_op(8'd0, 8'd3, "b0_3");
    run_op(8'd255, 8'd255, "b255_255");

    run_op(8'd77, 8'd0, "dbz");
    chk("dbz_flag_const", div_by_zero, 1);
    step();
    run_op(8'd10, 8'd3, "dbz_clear");
    chk("dbz_clear_const", div_by_zero, 0);

    dividend = 8'd200;
    divisor = 8'd7;
    start = 1'b1;
    sb.push_back(model(8'd200, 8'd7));
    nd = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      dividend = 8'($urandom_range(0, 255));
      divisor = 8'($urandom_range(0, 255));
      if (done) nd++;
    end
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        nd++;
        if (nd == 1 && sb.size() > 0) begin
          e = sb.pop_front();
          chk("hold_q", quotient, e.q);
          chk("hold_r", remainder, e.r);
        end
      end
      step();
    end
    chk("hold_npulse", nd, 1);
    sb.delete();

    run_op(8'd100, 8'd10, "b2b_1");
    run_op(8'd99, 8'd10, "b2b_2");
    step();

`ifdef DIV_SIGNED_EN
    run_op(8'hF9, 8'h02, "s_m7_2");
    chk("s_m7_2_const", {quotient, remainder}, 16'hFDFF);
    run_op(8'h07, 8'hFE, "s_7_m2");
    chk("s_7_m2_const", {quotient, remainder}, 16'hFD01);
    run_op(8'h80, 8'hFF, "s_ovf");
    chk("s_ovf_const", {quotient, remainder}, 16'h8000);
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(ra, rb, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
